// File: rtl/mux_arbiter2_pkg.sv
// Shared definitions for the two-channel round-robin packet arbiter.
package mux_arb_pkg;

    // Default width of the forwarded data word.
    localparam int DEFAULT_DATA_W = 8;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_e;

    // Grant identifiers, shared by last_grant and the mux select.
    localparam logic GRANT_IS_A = 1'b0;
    localparam logic GRANT_IS_B = 1'b1;

    // Round-robin pick from IDLE: a lone requester wins outright, and on
    // contention the channel that did not own the previous packet wins.
    function automatic state_e rr_pick(input logic a_req, input logic b_req,
                                       input logic last_grant);
        state_e pick;
        pick = IDLE;
        if (a_req && b_req) begin
            pick = (last_grant == GRANT_IS_A) ? GRANT_B : GRANT_A;
        end else if (a_req) begin
            pick = GRANT_A;
        end else if (b_req) begin
            pick = GRANT_B;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_arbiter2_if.sv
// Bundle of the two input packet channels, the output stream and the
// arbiter status signals.
//
// Handshake: a word moves across a channel on a rising edge where both
// valid and ready are high. The sender holds valid/data/last steady until
// that edge; ready may depend combinationally on the receiver's state but
// never on the sender's valid of the same cycle.
interface mux_arbiter2_if
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_last;
    logic              a_ready;

    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_last;
    logic              b_ready;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    logic              sel;
    logic              busy;

    // Arbiter side.
    modport slave (
        input  a_valid, a_data, a_last,
        input  b_valid, b_data, b_last,
        input  out_ready,
        output a_ready, b_ready,
        output out_valid, out_data, out_last,
        output sel, busy
    );

    // Traffic source / sink side.
    modport master (
        output a_valid, a_data, a_last,
        output b_valid, b_data, b_last,
        output out_ready,
        input  a_ready, b_ready,
        input  out_valid, out_data, out_last,
        input  sel, busy
    );

endinterface

// File: rtl/mux_arbiter2_mux2_w.sv
// Word-wide 2:1 mux carrying data plus the last flag; sel_i=1 picks b.
module mux2_w
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              a_last_i,
    input  logic [DATA_W-1:0] b_data_i,
    input  logic              b_last_i,
    input  logic              sel_i,
    output logic [DATA_W-1:0] y_data_o,
    output logic              y_last_o
);

    // Pure selection, no storage.
    always_comb begin
        y_data_o = a_data_i;
        y_last_o = a_last_i;
        if (sel_i == GRANT_IS_B) begin
            y_data_o = b_data_i;
            y_last_o = b_last_i;
        end
    end

endmodule

// File: rtl/mux_arbiter2.sv
// Two-channel round-robin packet arbiter with a one-word registered output.
// The grant is chosen in an IDLE cycle, then locked to one channel until
// that channel's last word is transferred.
module mux_arbiter2
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    mux_arbiter2_if.slave       bus,
    output logic [1:0]          state_o
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              sel_q, sel_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic              slot_free;
    logic              a_ready;
    logic              b_ready;
    logic              xfer;
    logic [DATA_W-1:0] mux_data;
    logic              mux_last;

    // The output register can take a word when empty or being drained now.
    assign slot_free = !out_valid_q || bus.out_ready;

    // sel_q tracks the grant, so in a GRANT state the mux already points
    // at the owning channel.
    mux2_w #(.DATA_W(DATA_W)) u_mux (
        .a_data_i (bus.a_data),
        .a_last_i (bus.a_last),
        .b_data_i (bus.b_data),
        .b_last_i (bus.b_last),
        .sel_i    (sel_q),
        .y_data_o (mux_data),
        .y_last_o (mux_last)
    );

    // Next-state, ready generation and grant bookkeeping.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        xfer         = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = rr_pick(bus.a_valid, bus.b_valid, last_grant_q);
            end
            GRANT_A: begin
                a_ready = slot_free;
                xfer    = bus.a_valid && slot_free;
                if (xfer && bus.a_last) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_IS_A;
                end
            end
            GRANT_B: begin
                b_ready = slot_free;
                xfer    = bus.b_valid && slot_free;
                if (xfer && bus.b_last) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_IS_B;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // sel follows the grant and keeps its value through IDLE.
        case (state_d)
            GRANT_A: sel_d = GRANT_IS_A;
            GRANT_B: sel_d = GRANT_IS_B;
            default: sel_d = sel_q;
        endcase
    end

    // Output register: load on transfer, otherwise drain or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_last_d  = mux_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any open packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IS_B;
            sel_q        <= GRANT_IS_A;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bus.a_ready   = a_ready;
    assign bus.b_ready   = b_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q != IDLE);
    assign state_o       = state_q;

endmodule

// File: tb/tb_mux_arbiter2.sv
// Bench for mux_arbiter2: cycle-exact vector table plus packet sequences
// checked through an expected-output queue.
module tb_mux_arbiter2;
    import mux_arb_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } word_t;

    typedef struct {
        logic       rst, av;
        logic [7:0] ad;
        logic       al, bv;
        logic [7:0] bd;
        logic       bl, ordy;
        logic       ar, br, ov;
        logic [7:0] od;
        logic       ol, sel, busy;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    mux_arbiter2_if #(.DATA_W(8)) bus_if ();

    mux_arbiter2 #(.DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if.slave),
        .state_o (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int          errors = 0;
    int          checks = 0;
    logic [8:0]  exp_q[$];
    logic        exp_sel_q[$];
    word_t       a_src[$];
    word_t       b_src[$];
    vec_t        tbl[19];
    logic        sb_en = 1'b0;
    logic        lock_chk = 1'b0;
    logic        a_open = 1'b0;
    logic        prev_ov = 1'b0;
    logic        prev_ordy = 1'b1;
    logic [7:0]  prev_od = '0;
    logic        prev_ol = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst_v, av, input logic [7:0] ad, input logic al, bv,
                                input logic [7:0] bd, input logic bl, ordy, ar, br, ov,
                                input logic [7:0] od, input logic ol, sel, busy);
        vec_t v;
        v.rst = rst_v; v.av = av; v.ad = ad; v.al = al; v.bv = bv; v.bd = bd; v.bl = bl;
        v.ordy = ordy; v.ar = ar; v.br = br; v.ov = ov; v.od = od; v.ol = ol;
        v.sel = sel; v.busy = busy;
        return v;
    endfunction

    task automatic drive_idle();
        bus_if.a_valid = 1'b0; bus_if.a_data = '0; bus_if.a_last = 1'b0;
        bus_if.b_valid = 1'b0; bus_if.b_data = '0; bus_if.b_last = 1'b0;
        bus_if.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        prev_ov = 1'b0;
        prev_ordy = 1'b1;
        a_open = 1'b0;
    endtask

    // Scoreboard / protocol monitor, run at the falling edge.
    task automatic monitor();
        logic [8:0] e;
        logic       was_open;
        if (bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {bus_if.out_last, bus_if.out_data}, 9'h1ff);
            end else begin
                e = exp_q.pop_front();
                check("out_word", {bus_if.out_last, bus_if.out_data}, e);
            end
        end
        if (prev_ov && !prev_ordy)
            check("hold_stable", {bus_if.out_valid, bus_if.out_last, bus_if.out_data},
                  {1'b1, prev_ol, prev_od});
        if (bus_if.out_valid && !bus_if.out_ready)
            check("bp_ready_low", {bus_if.a_ready, bus_if.b_ready}, 2'b00);
        was_open = a_open;
        if (lock_chk && was_open)
            check("lock_b_ready", bus_if.b_ready, 1'b0);
        if (bus_if.a_valid && bus_if.a_ready) begin
            void'(a_src.pop_front());
            a_open = !bus_if.a_last;
            if (exp_sel_q.size() == 0) check("sel_extra_a", 1'b1, 1'b0);
            else check("sel_at_accept_a", bus_if.sel, exp_sel_q.pop_front());
        end
        if (bus_if.b_valid && bus_if.b_ready) begin
            void'(b_src.pop_front());
            if (exp_sel_q.size() == 0) check("sel_extra_b", 1'b1, 1'b0);
            else check("sel_at_accept_b", bus_if.sel, exp_sel_q.pop_front());
        end
        prev_ov   = bus_if.out_valid;
        prev_ordy = bus_if.out_ready;
        prev_od   = bus_if.out_data;
        prev_ol   = bus_if.out_last;
    endtask

    // mode 0: free-running, 1: two stalled cycles, 2: b joins at cycle 2.
    task automatic run_auto(input int mode, input int budget);
        int cyc;
        cyc = 0;
        sb_en = 1'b1;
        lock_chk = (mode == 2);
        while ((a_src.size() != 0 || b_src.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
            if (mode == 2 && cyc == 2) b_src.push_back('{data: 8'h60, last: 1'b1});
            bus_if.a_valid = (a_src.size() != 0);
            bus_if.a_data  = bus_if.a_valid ? a_src[0].data : 8'h00;
            bus_if.a_last  = bus_if.a_valid ? a_src[0].last : 1'b0;
            bus_if.b_valid = (b_src.size() != 0);
            bus_if.b_data  = bus_if.b_valid ? b_src[0].data : 8'h00;
            bus_if.b_last  = bus_if.b_valid ? b_src[0].last : 1'b0;
            bus_if.out_ready = (mode == 1 && (cyc == 3 || cyc == 4)) ? 1'b0 : 1'b1;
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= budget) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete(); a_src.delete(); b_src.delete(); exp_sel_q.delete();
        end
        sb_en = 1'b0;
        lock_chk = 1'b0;
        drive_idle();
        @(negedge clk);
        check("drain_idle", {bus_if.busy, bus_if.out_valid, state_dbg}, {1'b0, 1'b0, IDLE});
        check("sel_all_used", exp_sel_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        //               rst av ad    al bv bd    bl ordy ar br ov od    ol sel busy
        tbl[0]  = mk(1, 1, 8'h11, 0, 1, 8'hB0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(1, 1, 8'h11, 0, 1, 8'hB0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[2]  = mk(0, 1, 8'h11, 0, 1, 8'hB0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[3]  = mk(0, 1, 8'h11, 0, 1, 8'hB0, 1, 1, 1, 0, 0, 8'h00, 0, 0, 1);
        tbl[4]  = mk(0, 1, 8'h22, 0, 1, 8'hB0, 1, 1, 1, 0, 1, 8'h11, 0, 0, 1);
        tbl[5]  = mk(0, 1, 8'h33, 1, 1, 8'hB0, 1, 1, 1, 0, 1, 8'h22, 0, 0, 1);
        tbl[6]  = mk(0, 0, 8'h00, 0, 1, 8'hB0, 1, 1, 0, 0, 1, 8'h33, 1, 0, 0);
        tbl[7]  = mk(0, 0, 8'h00, 0, 1, 8'hB0, 1, 1, 0, 1, 0, 8'h33, 1, 1, 1);
        tbl[8]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'hB0, 1, 1, 0);
        tbl[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'hB0, 1, 1, 0);
        tbl[10] = mk(0, 1, 8'hC1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'hB0, 1, 1, 0);
        tbl[11] = mk(0, 1, 8'hC1, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'hB0, 1, 0, 1);
        tbl[12] = mk(0, 1, 8'hC2, 0, 0, 8'h00, 0, 1, 1, 0, 1, 8'hC1, 0, 0, 1);
        tbl[13] = mk(1, 1, 8'hC3, 0, 1, 8'hD0, 1, 1, 1, 0, 1, 8'hC2, 0, 0, 1);
        tbl[14] = mk(0, 1, 8'hC3, 0, 1, 8'hD0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[15] = mk(0, 1, 8'hC3, 1, 1, 8'hD0, 1, 1, 1, 0, 0, 8'h00, 0, 0, 1);
        tbl[16] = mk(0, 0, 8'h00, 0, 1, 8'hD0, 1, 1, 0, 0, 1, 8'hC3, 1, 0, 0);
        tbl[17] = mk(0, 0, 8'h00, 0, 1, 8'hD0, 1, 1, 0, 1, 0, 8'hC3, 1, 1, 1);
        tbl[18] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'hD0, 1, 1, 0);

        // Reset asserted from time zero with both channels requesting.
        rst = 1'b1;
        drive_idle();
        bus_if.a_valid = 1'b1; bus_if.a_data = 8'h11;
        bus_if.b_valid = 1'b1; bus_if.b_data = 8'hB0; bus_if.b_last = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            rst              = tbl[i].rst;
            bus_if.a_valid   = tbl[i].av;
            bus_if.a_data    = tbl[i].ad;
            bus_if.a_last    = tbl[i].al;
            bus_if.b_valid   = tbl[i].bv;
            bus_if.b_data    = tbl[i].bd;
            bus_if.b_last    = tbl[i].bl;
            bus_if.out_ready = tbl[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {bus_if.a_ready, bus_if.b_ready, bus_if.out_valid, bus_if.out_data,
                   bus_if.out_last, bus_if.sel, bus_if.busy},
                  {tbl[i].ar, tbl[i].br, tbl[i].ov, tbl[i].od, tbl[i].ol, tbl[i].sel, tbl[i].busy});
            @(posedge clk);
            #1;
        end

        // Round-robin with one-word packets on both channels.
        do_reset();
        a_src.push_back('{data: 8'hA0, last: 1'b1});
        a_src.push_back('{data: 8'hA1, last: 1'b1});
        b_src.push_back('{data: 8'hB0, last: 1'b1});
        b_src.push_back('{data: 8'hB1, last: 1'b1});
        exp_q.push_back({1'b1, 8'hA0}); exp_q.push_back({1'b1, 8'hB0});
        exp_q.push_back({1'b1, 8'hA1}); exp_q.push_back({1'b1, 8'hB1});
        exp_sel_q.push_back(1'b0); exp_sel_q.push_back(1'b1);
        exp_sel_q.push_back(1'b0); exp_sel_q.push_back(1'b1);
        run_auto(0, 40);

        // Backpressure during a three-word packet.
        do_reset();
        a_src.push_back('{data: 8'h41, last: 1'b0});
        a_src.push_back('{data: 8'h42, last: 1'b0});
        a_src.push_back('{data: 8'h43, last: 1'b1});
        exp_q.push_back({1'b0, 8'h41}); exp_q.push_back({1'b0, 8'h42});
        exp_q.push_back({1'b1, 8'h43});
        repeat (3) exp_sel_q.push_back(1'b0);
        run_auto(1, 40);

        // Lock: b requests while a four-word packet is open.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_src.push_back('{data: 8'h51 + 8'(i), last: (i == 3)});
            exp_q.push_back({(i == 3), 8'h51 + 8'(i)});
            exp_sel_q.push_back(1'b0);
        end
        exp_q.push_back({1'b1, 8'h60});
        exp_sel_q.push_back(1'b1);
        run_auto(2, 40);

        // Random single-channel packets of random length.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                logic [7:0] d;
                d = 8'($urandom_range(0, 255));
                a_src.push_back('{data: d, last: (i == n - 1)});
                exp_q.push_back({(i == n - 1), d});
                exp_sel_q.push_back(1'b0);
            end
        end
        run_auto(0, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
